// File: rtl/dot_product_stream.sv
// ----------------------------------------------------------------------------
// dot_product_stream
//   Sequential dot-product engine. Element pairs (a_i, b_i) arrive one beat at
//   a time, a single MAC accumulates a_i*b_i, and the unsigned sum plus the
//   vector length are presented on a result stream.
//
//   Handshake (both streams): a transfer happens on a rising clock edge where
//   valid & ready are both 1. A producer holds valid and its payload stable
//   until the transfer. Ready never depends on valid. Payload is sampled only
//   on a transfer, so it may be X at any other time.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      element pair valid
//   in_ready   out  1      engine accepts a pair (low while a result is held)
//   in_a       in   W      element a_i (unsigned)
//   in_b       in   W      element b_i (unsigned)
//   in_last    in   1      final element of the vector
//   out_valid  out  1      result valid, held until accepted
//   out_ready  in   1      consumer accepts the result
//   out_data   out  RES_W  sum(a_i*b_i)
//   out_len    out  CNT_W  beats in the vector (1..LEN)
// ----------------------------------------------------------------------------
module dot_product_stream #(
    parameter int W     = 8,
    parameter int LEN   = 8,
    parameter int RES_W = 2*W + $clog2(LEN),
    parameter int CNT_W = $clog2(LEN+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_data,
    output logic [CNT_W-1:0] out_len
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no vector in progress
        ACC  = 2'd1,  // vector in progress
        DONE = 2'd2   // result presented
    } state_t;

    state_t           state;
    logic [RES_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic             beat;
    logic [2*W-1:0]   prod;
    logic [RES_W-1:0] acc_base;
    logic [CNT_W-1:0] cnt_base;
    logic [RES_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             term;

    // One bubble per vector: the engine refuses input while a result is held.
    assign in_ready = (state != DONE);
    assign beat     = in_valid & in_ready;

    always_comb begin
        prod     = in_a * in_b;
        // A beat in IDLE starts a fresh vector, so it ignores any stale acc/cnt.
        acc_base = (state == IDLE) ? '0 : acc;
        cnt_base = (state == IDLE) ? '0 : cnt;
        acc_next = acc_base + {{(RES_W-2*W){1'b0}}, prod};
        cnt_next = cnt_base + {{(CNT_W-1){1'b0}}, 1'b1};
        // in_last on the LEN-th beat is a single termination, not two.
        term     = in_last | (cnt_next == CNT_W'(LEN));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_len   <= '0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (beat) begin
                        acc <= acc_next;
                        cnt <= cnt_next;
                        if (term) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= acc_next;
                            out_len   <= cnt_next;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                DONE: begin
                    // out_data/out_len keep their value after acceptance; they
                    // are only meaningful while out_valid is high.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    acc       <= '0;
                    cnt       <= '0;
                end
            endcase
        end
    end

endmodule
